pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It generates per-stage write enables and bubble/flush controls from the load-use, taken-branch and unified-memory structural hazards. It owns the single memory port, with data accesses taking priority over fetch. It runs alongside the forwarding unit, which covers the remaining RAW hazards, and keeps saturating stall/flush performance counters.

Parameters:
REG_W, 5, register index width
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
IF_ID_rs1  in  REG_W  rs1 of instruction in ID
IF_ID_rs2  in  REG_W  rs2 of instruction in ID
ID_EX_rd  in  REG_W  rd of instruction in EX
ID_EX_memrd  in  1  instruction in EX is a load
EX_branch_taken  in  1  branch/jump resolved taken in EX
EX_MEM_memrd  in  1  load in MEM
EX_MEM_memwr  in  1  store in MEM
mem_ready  in  1  memory completes the current request this cycle
cnt_clr  in  1  synchronous counter clear
pc_write  out  1  PC load enable (sequential PC or branch target)
IF_ID_write  out  1  IF/ID load enable
IF_ID_flush  out  1  load NOP into IF/ID
ID_EX_write  out  1  ID/EX load enable
ID_EX_bubble  out  1  load NOP into ID/EX
EX_MEM_write  out  1  EX/MEM load enable
MEM_WB_bubble  out  1  load NOP into MEM/WB
mem_req  out  1  memory request valid
mem_sel  out  1  0 = instruction fetch, 1 = data access
state  out  1  0 = S_FETCH, 1 = S_DATA
stall_cnt  out  CNT_W  cycles with pc_write = 0 (reset excluded)
flush_cnt  out  CNT_W  taken-branch flushes performed

Behaviour:
- Reset (rst_n = 0, asynchronous): state = S_FETCH, both counters = 0. All write enables = 0; IF_ID_flush, ID_EX_bubble and MEM_WB_bubble = 1; mem_req = 0, mem_sel = 0. A reset asserted in S_DATA aborts the access.
- Definitions:
  - dacc = EX_MEM_memrd | EX_MEM_memwr.
  - lu = ID_EX_memrd & (ID_EX_rd != 0) & (ID_EX_rd == IF_ID_rs1 | ID_EX_rd == IF_ID_rs2).
- Memory port: mem_req = 1 whenever out of reset. mem_sel = dacc | (state == S_DATA).
- freeze = mem_sel & !mem_ready. During freeze:
  - pc_write = IF_ID_write = ID_EX_write = EX_MEM_write = 0.
  - MEM_WB_bubble = 1; IF_ID_flush = 0, ID_EX_bubble = 0.
  - Branch and load-use are ignored while frozen; the held EX instruction keeps presenting them.
- State transitions:
  - S_FETCH -> S_DATA when freeze.
  - S_DATA -> S_FETCH when mem_ready.
  - A data access completing in its first cycle stays in S_FETCH.
- Not frozen: ID_EX_write = EX_MEM_write = 1 and MEM_WB_bubble = 0. The remaining controls are resolved in this priority order:
  1. EX_branch_taken: pc_write = 1 (target), IF_ID_flush = 1, ID_EX_bubble = 1; flush_cnt++. A coincident lu is discarded.
  2. lu: pc_write = 0, IF_ID_write = 0 (hold), IF_ID_flush = 0, ID_EX_bubble = 1. Exactly one bubble per load-use, since the load leaves EX next cycle.
  3. Fetch not delivered (mem_sel = 1, or fetch with mem_ready = 0): pc_write = 0, IF_ID_write = 1, IF_ID_flush = 1 (fetch bubble).
  4. Otherwise: pc_write = 1, IF_ID_write = 1, no bubbles.
- Counters:
  - stall_cnt increments every out-of-reset cycle with pc_write = 0.
  - Both counters saturate at all-ones.
  - cnt_clr has priority over increment; clearing takes effect next edge.
- Latency: all controls are combinational from inputs and state. Only state and the counters are registered.
- With mem_ready tied to 1, every load/store costs exactly one fetch bubble and S_DATA is never entered.

Decomposition:
- Shared pipeline package: state encoding (S_FETCH/S_DATA), MEM_SEL_FETCH/MEM_SEL_DATA constants, and the NOP encoding used by the flush/bubble logic.
- One natural sub-module, sat_counter (CNT_W, inc, clr), instantiated twice.

Test Plan:
- Load x5 in EX (ID_EX_memrd = 1, rd = 5), ID reads rs2 = 5, mem_ready = 1 -> one cycle with pc_write = 0, IF_ID_write = 0, ID_EX_bubble = 1; stall_cnt = 1; the same case with rd = 0 gives no stall.
- EX_branch_taken = 1 together with lu -> pc_write = 1, IF_ID_flush = 1, ID_EX_bubble = 1, IF_ID_write held at 1; flush_cnt 0 -> 1.
- Store in MEM, mem_ready low for 3 cycles then high -> state 0,1,1,1,0. During the 3 frozen cycles: mem_sel = 1, all enables 0, MEM_WB_bubble = 1. The ready cycle gives a fetch bubble (IF_ID_flush = 1). stall_cnt = 4.
- Fetch with mem_ready = 0, no hazards -> pc_write = 0, IF_ID_flush = 1, ID_EX_write = EX_MEM_write = 1, state stays 0.
- rst_n pulled low mid-S_DATA -> state = 0, counters = 0, mem_req = 0 immediately. After release, the first cycle gives mem_req = 1, mem_sel = 0.
- Preload stall_cnt near all-ones, keep stalling -> it saturates at all-ones. cnt_clr = 1 concurrent with a stall -> stall_cnt = 0 next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: sequencer state encoding, memory port select
// values and the NOP instruction loaded by flush/bubble muxes.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_DATA  = 1'b1
    } state_e;

    localparam logic MEM_SEL_FETCH = 1'b0;
    localparam logic MEM_SEL_DATA  = 1'b1;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use, taken-branch
// and shared memory port arbitration, plus stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] IF_ID_rs1,
    input  logic [REG_W-1:0] IF_ID_rs2,
    input  logic [REG_W-1:0] ID_EX_rd,
    input  logic             ID_EX_memrd,
    input  logic             EX_branch_taken,
    input  logic             EX_MEM_memrd,
    input  logic             EX_MEM_memwr,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_write,
    output logic             MEM_WB_bubble,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e state_q, state_d;
    logic   dacc, lu, freeze;
    logic   stall_inc, flush_inc;

    assign dacc = EX_MEM_memrd | EX_MEM_memwr;
    assign lu   = ID_EX_memrd && (ID_EX_rd != '0) &&
                  ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));

    assign mem_sel = rst_n && (dacc || (state_q == S_DATA)) ? MEM_SEL_DATA : MEM_SEL_FETCH;
    assign mem_req = rst_n;
    assign freeze  = mem_sel && !mem_ready;

    always_comb begin
        pc_write      = 1'b0;
        IF_ID_write   = 1'b0;
        IF_ID_flush   = 1'b1;
        ID_EX_write   = 1'b0;
        ID_EX_bubble  = 1'b1;
        EX_MEM_write  = 1'b0;
        MEM_WB_bubble = 1'b1;
        flush_inc     = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                // Whole pipe holds; branch/load-use are re-presented after the access.
                IF_ID_flush  = 1'b0;
                ID_EX_bubble = 1'b0;
            end else begin
                ID_EX_write   = 1'b1;
                EX_MEM_write  = 1'b1;
                MEM_WB_bubble = 1'b0;
                if (EX_branch_taken) begin
                    pc_write     = 1'b1;
                    IF_ID_write  = 1'b1;
                    IF_ID_flush  = 1'b1;
                    ID_EX_bubble = 1'b1;
                    flush_inc    = 1'b1;
                end else if (lu) begin
                    IF_ID_flush  = 1'b0;
                end else if (mem_sel || !mem_ready) begin
                    IF_ID_write  = 1'b1;
                    ID_EX_bubble = 1'b0;
                end else begin
                    pc_write     = 1'b1;
                    IF_ID_write  = 1'b1;
                    IF_ID_flush  = 1'b0;
                    ID_EX_bubble = 1'b0;
                end
            end
        end
    end

    assign stall_inc = rst_n && !pc_write;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (freeze)    state_d = S_DATA;
            S_DATA:  if (mem_ready) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (cnt_clr),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .clr   (cnt_clr),
        .cnt   (flush_cnt)
    );

endmodule
